uart_mem_bridge: RTL and testbench

Command executor directly downstream of the UART frame receiver. It consumes one decoded command per `cmd_valid` pulse (read/write flag, memory select, 9-bit word address, 32-bit data). It performs a single-word access on the instruction or data memory port. For reads, it streams the 32-bit result back MSB-first as four bytes over a valid/ready byte interface toward the UART transmitter. It also holds the CPU while a host access is in flight.

---
 rtl/uart_bridge_pkg.sv | 32 +++
 rtl/bridge_tx_seq.sv | 53 +++++
 rtl/uart_mem_bridge.sv | 165 ++++++++++++++++
 tb/tb_uart_mem_bridge.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// =============================================================================
// Module   : uart_bridge_pkg
// Purpose  : Shared state encoding and constants for the UART memory bridge.
//            Optional echo feature: UART_BRIDGE_ECHO_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package uart_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        RD_REQ = 3'd2,
        TX     = 3'd3
`ifdef UART_BRIDGE_ECHO_EN
        ,
        ECHO   = 3'd4
`endif
    } bridge_state_t;

    localparam logic MEM_IMEM = 1'b0;
    localparam logic MEM_DMEM = 1'b1;

`ifdef UART_BRIDGE_ECHO_EN
    localparam logic [7:0] ACK_OK      = 8'hA5;
    localparam logic [7:0] ACK_TIMEOUT = 8'hE1;
`endif

endpackage

`default_nettype wire

// File: rtl/bridge_tx_seq.sv
// =============================================================================
// Module   : bridge_tx_seq
// Purpose  : Emits a loaded 32-bit word (4 bytes) or a single byte MSB-first
//            over a valid/ready byte interface; pulses o_done on the last byte.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module bridge_tx_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_four,
    input  logic [31:0] i_word,
    input  logic [7:0]  i_byte,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [7:0]  o_data,
    output logic        o_done
);

    logic [31:0] r_buf;
    logic [1:0]  r_idx;
    logic        r_valid;
    logic        w_hs;

    assign w_hs    = r_valid & i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_buf[{r_idx, 3'b000} +: 8];
    assign o_done  = w_hs & (r_idx == 2'd0);

    // A single byte sits in the low lane so index 0 is always the final byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_buf   <= i_four ? i_word : {24'h000000, i_byte};
            r_idx   <= i_four ? 2'd3 : 2'd0;
            r_valid <= 1'b1;
        end else if (w_hs) begin
            if (r_idx == 2'd0) begin
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx - 2'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_mem_bridge.sv
// =============================================================================
// Module   : uart_mem_bridge
// Purpose  : Executes decoded UART commands as single-word memory accesses and
//            streams read data back as bytes. Optional: UART_BRIDGE_ECHO_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module uart_mem_bridge
    import uart_bridge_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic              cmd_rw,
    input  logic              cmd_mem_type,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              cpu_hold,
    output logic              err_overrun,
    output logic              err_timeout,
    input  logic              err_clr
);

    bridge_state_t     r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic              r_mem_sel;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_cpu_hold;
    logic              r_err_overrun;
    logic              r_err_timeout;
    logic [7:0]        r_tmo;

    logic              w_in_req;
    logic              w_tmo;
    logic              w_rd_ack;
    logic              w_seq_load;
    logic [7:0]        w_seq_byte;
    logic              w_seq_done;

    assign w_in_req = (r_state == WR_REQ) || (r_state == RD_REQ);
    // An ack on the cycle the counter hits zero still wins over the timeout.
    assign w_tmo    = w_in_req && !mem_ack && (r_tmo == 8'd0);
    assign w_rd_ack = (r_state == RD_REQ) && mem_ack;

`ifdef UART_BRIDGE_ECHO_EN
    assign w_seq_load = w_rd_ack || ((r_state == WR_REQ) && mem_ack) || w_tmo;
    assign w_seq_byte = w_tmo ? ACK_TIMEOUT : ACK_OK;
`else
    assign w_seq_load = w_rd_ack;
    assign w_seq_byte = 8'h00;
`endif

    bridge_tx_seq u_tx_seq (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_seq_load),
        .i_four  (w_rd_ack),
        .i_word  (mem_rdata),
        .i_byte  (w_seq_byte),
        .i_ready (tx_ready),
        .o_valid (tx_valid),
        .o_data  (tx_data),
        .o_done  (w_seq_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_sel     <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_cpu_hold    <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_timeout <= 1'b0;
            r_tmo         <= 8'd0;
        end else begin
            r_err_overrun <= (cmd_valid && (r_state != IDLE)) || (r_err_overrun && !err_clr);
            r_err_timeout <= w_tmo || (r_err_timeout && !err_clr);

            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_mem_sel   <= cmd_mem_type;
                        r_mem_addr  <= cmd_addr;
                        r_mem_wdata <= cmd_data;
                        r_tmo       <= 8'(MEM_TIMEOUT);
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= cmd_rw;
                        r_cpu_hold  <= 1'b1;
                        r_state     <= cmd_rw ? WR_REQ : RD_REQ;
                    end
                end
                WR_REQ, RD_REQ: begin
                    if (mem_ack || w_tmo) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (w_rd_ack) begin
                            r_state <= TX;
                        end else begin
`ifdef UART_BRIDGE_ECHO_EN
                            r_state    <= ECHO;
`else
                            r_state    <= IDLE;
                            r_cpu_hold <= 1'b0;
`endif
                        end
                    end else begin
                        r_tmo <= r_tmo - 8'd1;
                    end
                end
                TX: begin
                    if (w_seq_done) begin
                        r_state    <= IDLE;
                        r_cpu_hold <= 1'b0;
                    end
                end
`ifdef UART_BRIDGE_ECHO_EN
                ECHO: begin
                    if (w_seq_done) begin
                        r_state    <= IDLE;
                        r_cpu_hold <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state    <= IDLE;
                    r_mem_req  <= 1'b0;
                    r_mem_we   <= 1'b0;
                    r_cpu_hold <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_sel     = r_mem_sel;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign cpu_hold    = r_cpu_hold;
    assign err_overrun = r_err_overrun;
    assign err_timeout = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_uart_mem_bridge.sv
// =============================================================================
// Module   : tb_uart_mem_bridge
// Purpose  : Self-checking bench for uart_mem_bridge with a tx byte scoreboard.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_uart_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_rw, cmd_mem_type;
    logic [8:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        mem_req, mem_we, mem_sel;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic        cpu_hold, err_overrun, err_timeout, err_clr;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  sb[$];

    uart_mem_bridge #(.ADDR_W(9), .DATA_W(32), .MEM_TIMEOUT(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_rw       (cmd_rw),
        .cmd_mem_type (cmd_mem_type),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .cpu_hold     (cpu_hold),
        .err_overrun  (err_overrun),
        .err_timeout  (err_timeout),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    // Inputs only change 1ns after a rising edge, so the falling edge sees what
    // the next rising edge will sample.
    always @(negedge clk) begin
        if (reset === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL tx_unexpected: got byte %02h, expected no byte", tx_data);
            end else begin
                logic [7:0] exp;
                exp = sb.pop_front();
                if (tx_data !== exp) begin
                    n_errors++;
                    $display("FAIL tx_byte: got %02h, expected %02h", tx_data, exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic rw, input logic mt, input logic [8:0] a, input logic [31:0] d);
        cmd_valid    = 1'b1;
        cmd_rw       = rw;
        cmd_mem_type = mt;
        cmd_addr     = a;
        cmd_data     = d;
        tick();
        cmd_valid    = 1'b0;
    endtask

    task automatic do_read(input logic mt, input logic [8:0] a, input logic [31:0] d);
        logic [7:0] exp;
        for (int k = 0; k < 4; k++) sb.push_back(8'(d >> (24 - 8 * k)));
        tx_ready = 1'b1;
        send_cmd(1'b0, mt, a, 32'h0);
        n_checks++;
        if ({mem_req, mem_we, cpu_hold} !== 3'b101) begin
            n_errors++;
            $display("FAIL rd_req: got req/we/hold=%b, expected 101", {mem_req, mem_we, cpu_hold});
        end
        mem_ack   = 1'b1;
        mem_rdata = d;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL rd_req_drop: got mem_req=%b, expected 0", mem_req);
        end
        for (int k = 0; k < 4; k++) begin
            exp = 8'(d >> (24 - 8 * k));
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp) begin
                n_errors++;
                $display("FAIL rd_stream[%0d]: got valid=%b data=%02h, expected valid=1 data=%02h",
                         k, tx_valid, tx_data, exp);
            end
            tick();
        end
        n_checks++;
        if (cpu_hold !== 1'b0 || tx_valid !== 1'b0 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL rd_done: got hold=%b valid=%b pending=%0d, expected 0 0 0",
                     cpu_hold, tx_valid, sb.size());
        end
        n_checks++;
        if (mem_sel !== mt || mem_addr !== a) begin
            n_errors++;
            $display("FAIL rd_latch: got sel=%b addr=%03h, expected sel=%b addr=%03h", mem_sel, mem_addr, mt, a);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({mem_req, mem_we, mem_sel, mem_addr, mem_wdata, tx_data, tx_valid,
             cpu_hold, err_overrun, err_timeout} !== 56'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got req=%b we=%b hold=%b txv=%b addr=%03h, expected all 0",
                     mem_req, mem_we, cpu_hold, tx_valid, mem_addr);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write();
        int cnt = 0;
        int we_bad = 0;
`ifdef UART_BRIDGE_ECHO_EN
        sb.push_back(8'hA5);
`endif
        tx_ready = 1'b1;
        send_cmd(1'b1, 1'b0, 9'h012, 32'hDEADBEEF);
        for (int i = 0; i < 12; i++) begin
            if (mem_req === 1'b1) begin
                cnt++;
                if (mem_we !== 1'b1) we_bad++;
            end
            mem_ack = (mem_req === 1'b1 && cnt == 3);
            tick();
        end
        mem_ack = 1'b0;
        n_checks++;
        if (cnt != 3 || we_bad != 0) begin
            n_errors++;
            $display("FAIL wr_req_cycles: got %0d cycles (%0d without we), expected 3", cnt, we_bad);
        end
        n_checks++;
        if (mem_sel !== 1'b0 || mem_addr !== 9'h012 || mem_wdata !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL wr_latch: got sel=%b addr=%03h wdata=%08h, expected 0 012 deadbeef",
                     mem_sel, mem_addr, mem_wdata);
        end
        n_checks++;
        if (cpu_hold !== 1'b0 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL wr_done: got hold=%b pending=%0d, expected 0 0", cpu_hold, sb.size());
        end
    endtask

    task automatic test_read();
        do_read(1'b1, 9'h1FF, 32'h12345678);
    endtask

    task automatic test_tx_backpressure();
        logic [3:0] pat = 4'b1001;
        int         hs = 0;
        logic       was_stalled = 1'b0;
        logic [7:0] held = 8'h00;
        sb.push_back(8'h9A);
        sb.push_back(8'hBC);
        sb.push_back(8'hDE);
        sb.push_back(8'hF0);
        tx_ready = 1'b0;
        send_cmd(1'b0, 1'b0, 9'h0C3, 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h9ABCDEF0;
        tick();
        mem_ack   = 1'b0;
        for (int i = 0; i < 40 && cpu_hold === 1'b1; i++) begin
            tx_ready = pat[3 - (i % 4)];
            if (was_stalled) begin
                n_checks++;
                if (tx_valid !== 1'b1 || tx_data !== held) begin
                    n_errors++;
                    $display("FAIL bp_stable: got valid=%b data=%02h, expected valid=1 data=%02h",
                             tx_valid, tx_data, held);
                end
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) hs++;
            was_stalled = (tx_valid === 1'b1 && tx_ready === 1'b0);
            held        = tx_data;
            tick();
        end
        tx_ready = 1'b0;
        n_checks++;
        if (hs != 4 || cpu_hold !== 1'b0 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL bp_handshakes: got %0d handshakes hold=%b pending=%0d, expected 4 0 0",
                     hs, cpu_hold, sb.size());
        end
    endtask

    task automatic test_timeout();
        int cnt = 0;
`ifdef UART_BRIDGE_ECHO_EN
        sb.push_back(8'hE1);
`endif
        tx_ready = 1'b1;
        send_cmd(1'b0, 1'b1, 9'h055, 32'h0);
        for (int i = 0; i < 40; i++) begin
            if (mem_req === 1'b1) cnt++;
            tick();
        end
        n_checks++;
        if (cnt != 16) begin
            n_errors++;
            $display("FAIL tmo_cycles: got %0d request cycles, expected 16", cnt);
        end
        n_checks++;
        if (err_timeout !== 1'b1 || cpu_hold !== 1'b0 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL tmo_state: got err=%b hold=%b pending=%0d, expected 1 0 0",
                     err_timeout, cpu_hold, sb.size());
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        n_checks++;
        if (err_timeout !== 1'b1 || cpu_hold !== 1'b0 || mem_req !== 1'b0 || tx_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL tmo_sticky: got err=%b hold=%b req=%b txv=%b, expected 1 0 0 0",
                     err_timeout, cpu_hold, mem_req, tx_valid);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if (err_timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL tmo_clear: got err_timeout=%b, expected 0", err_timeout);
        end
    endtask

    task automatic test_overrun();
        int cnt = 0;
        sb.push_back(8'hCA);
        sb.push_back(8'hFE);
        sb.push_back(8'hF0);
        sb.push_back(8'h0D);
        tx_ready = 1'b1;
        send_cmd(1'b0, 1'b1, 9'h0AA, 32'h0);
        // Second command arrives together with err_clr: the new error must stick.
        err_clr = 1'b1;
        send_cmd(1'b1, 1'b0, 9'h155, 32'h55555555);
        err_clr = 1'b0;
        n_checks++;
        if (err_overrun !== 1'b1 || mem_addr !== 9'h0AA || mem_we !== 1'b0 || mem_req !== 1'b1) begin
            n_errors++;
            $display("FAIL ovr_flag: got err=%b addr=%03h we=%b req=%b, expected 1 0aa 0 1",
                     err_overrun, mem_addr, mem_we, mem_req);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        for (int i = 0; i < 12; i++) begin
            if (mem_req === 1'b1) cnt++;
            tick();
        end
        n_checks++;
        if (cnt != 0 || sb.size() != 0 || cpu_hold !== 1'b0 || mem_addr !== 9'h0AA || mem_wdata !== 32'h0) begin
            n_errors++;
            $display("FAIL ovr_dropped: got req_cycles=%0d pending=%0d hold=%b addr=%03h, expected 0 0 0 0aa",
                     cnt, sb.size(), cpu_hold, mem_addr);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if (err_overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL ovr_clear: got err_overrun=%b, expected 0", err_overrun);
        end
    endtask

    task automatic test_back_to_back();
`ifndef UART_BRIDGE_ECHO_EN
        send_cmd(1'b1, 1'b1, 9'h001, 32'h00000001);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_checks++;
        if (mem_req !== 1'b0 || cpu_hold !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_idle: got req=%b hold=%b, expected 0 0", mem_req, cpu_hold);
        end
        send_cmd(1'b1, 1'b1, 9'h002, 32'h00000002);
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 9'h002 || err_overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_accept: got req=%b addr=%03h ovr=%b, expected 1 002 0",
                     mem_req, mem_addr, err_overrun);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_checks++;
        if (mem_req !== 1'b0 || mem_wdata !== 32'h00000002) begin
            n_errors++;
            $display("FAIL b2b_done: got req=%b wdata=%08h, expected 0 00000002", mem_req, mem_wdata);
        end
`endif
    endtask

    task automatic test_reset_mid_tx();
        sb.push_back(8'hA1);
        sb.push_back(8'hB2);
        tx_ready = 1'b1;
        send_cmd(1'b0, 1'b1, 9'h033, 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hA1B2C3D4;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        tick();
        tick();
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hC3) begin
            n_errors++;
            $display("FAIL rst_partial: got valid=%b data=%02h, expected 1 c3", tx_valid, tx_data);
        end
        tx_ready = 1'b0;
        reset    = 1'b1;
        tick();
        n_checks++;
        if ({mem_req, mem_we, mem_sel, mem_addr, mem_wdata, tx_data, tx_valid,
             cpu_hold, err_overrun, err_timeout} !== 56'h0 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL rst_mid_tx: got txv=%b data=%02h hold=%b addr=%03h pending=%0d, expected all 0",
                     tx_valid, tx_data, cpu_hold, mem_addr, sb.size());
        end
        reset = 1'b0;
        tick();
        do_read(1'b0, 9'h100, 32'h0F1E2D3C);
    endtask

    initial begin
        reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_rw       = 1'b0;
        cmd_mem_type = 1'b0;
        cmd_addr     = 9'h0;
        cmd_data     = 32'h0;
        mem_rdata    = 32'h0;
        mem_ack      = 1'b0;
        tx_ready     = 1'b0;
        err_clr      = 1'b0;

        test_reset();
        test_write();
        test_read();
        test_tx_backpressure();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_reset_mid_tx();

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
